// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter: shares one single-port pipelined framebuffer memory between
// the real-time display fetch (burst reads into the external pixel FIFO) and
// the draw-engine write port. The display owns the memory whenever its FIFO is
// below the low watermark; a draw write takes the memory otherwise.
// The frame pointer restarts on the falling edge of dnextframe (vsync entry).
// Optional build: define FB_DOUBLE_BUFFER_EN for double-buffered display with
// swap_req taking effect on the next frame restart.
module fb_mem_arbiter #(
  parameter int AW          = 16,
  parameter int FRAME_WORDS = 19200,
  parameter int FB_BASE0    = 0,
  parameter int FB_BASE1    = 19200,
  parameter int BURST_LEN   = 16,
  parameter int LOW_WM      = 32,
  parameter int FIFO_DEPTH  = 64,
  parameter int MEM_LAT     = 2,
  parameter int DW          = 256
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          dfetch,
  input  logic          dnextframe,
  input  logic [6:0]    fifo_level,
  output logic [DW-1:0] dout_data,
  output logic          dout_valid,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  input  logic          swap_req,
  output logic          disp_buf,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, DBURST, WRITE} state_e;

  // A burst is only started if a full burst still fits in the FIFO, so the
  // effective watermark never exceeds FIFO_DEPTH-BURST_LEN.
  localparam int            LWM_EFF   = (LOW_WM < FIFO_DEPTH - BURST_LEN) ?
                                        LOW_WM : FIFO_DEPTH - BURST_LEN;
  localparam logic [6:0]    LWM_C     = 7'(LWM_EFF);
  localparam logic [5:0]    BCNT_INIT = 6'(BURST_LEN - 1);
  localparam logic [AW-1:0] PTR_LAST  = AW'(FRAME_WORDS - 1);
  localparam logic [AW-1:0] BASE0     = AW'(FB_BASE0);
  localparam logic [AW-1:0] BASE1     = AW'(FB_BASE1);

  state_e          state_q;
  logic [AW-1:0]   dptr_q, waddr_q, base, dptr_nxt;
  logic [DW-1:0]   wdata_q;
  logic [5:0]      cnt_q;
  logic            dnf_q, restart, rd_issue, start_rd, is_wr, disp_buf_w;
  logic [MEM_LAT:1] vld_pipe;

  // Frame restart is the 1->0 edge of dnextframe; it acts in the edge cycle.
  assign restart  = dnf_q & ~dnextframe;
  // A read leaves only while bursting, fetching, and not restarting.
  assign rd_issue = (state_q == DBURST) & dfetch & ~restart;
  assign start_rd = dfetch & (fifo_level < LWM_C) & ~restart;
  assign is_wr    = (state_q == WRITE);
  assign dptr_nxt = (dptr_q == PTR_LAST) ? '0 : dptr_q + 1'b1;
  assign base     = disp_buf_w ? BASE1 : BASE0;

  // Delayed copy of dnextframe for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) dnf_q <= 1'b0;
    else          dnf_q <= dnextframe;
  end

  // Arbitration FSM: display bursts have priority, writes take one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      dptr_q  <= '0;
      cnt_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_rd) begin
            state_q <= DBURST;
            cnt_q   <= BCNT_INIT;
          end else if (wr_req) begin
            state_q <= WRITE;
            waddr_q <= wr_addr;
            wdata_q <= wr_data;
          end
        end
        DBURST: begin
          // Restart or loss of dfetch ends the burst with no read this cycle.
          if (!rd_issue) begin
            state_q <= IDLE;
          end else begin
            dptr_q <= dptr_nxt;
            if (cnt_q == 6'd0) begin
              // Last read: a pending write gets the very next cycle.
              if (wr_req) begin
                state_q <= WRITE;
                waddr_q <= wr_addr;
                wdata_q <= wr_data;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        WRITE:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (restart) dptr_q <= '0;
    end
  end

  // Read tag delay line; a restart drops every tag still in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
    end else if (restart) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_issue;
      for (int k = 2; k <= MEM_LAT; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

`ifdef FB_DOUBLE_BUFFER_EN
  logic disp_buf_q, swap_pend_q;

  // Sticky swap request, applied (with a same-cycle request) on restart.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disp_buf_q  <= 1'b0;
      swap_pend_q <= 1'b0;
    end else if (restart) begin
      disp_buf_q  <= disp_buf_q ^ (swap_pend_q | swap_req);
      swap_pend_q <= 1'b0;
    end else if (swap_req) begin
      swap_pend_q <= 1'b1;
    end
  end
  assign disp_buf_w = disp_buf_q;
`else
  logic unused_swap;
  assign unused_swap = swap_req;
  assign disp_buf_w  = 1'b0;
`endif

  assign disp_buf   = disp_buf_w;
  assign mem_en     = rd_issue | is_wr;
  assign mem_we     = is_wr;
  assign wr_ack     = is_wr;
  assign mem_addr   = is_wr ? waddr_q : (rd_issue ? base + dptr_q : '0);
  assign mem_wdata  = is_wr ? wdata_q : '0;
  assign dout_valid = vld_pipe[MEM_LAT];
  assign dout_data  = dout_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Directed bench for fb_mem_arbiter (default single-buffer build).
module tb_fb_mem_arbiter;
  localparam int AW = 16, DW = 256;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic          dfetch = 1'b0, dnextframe = 1'b1, wr_req = 1'b0, swap_req = 1'b0;
  logic [6:0]    fifo_drv = 7'd40, fifo_level;
  logic [AW-1:0] wr_addr = '0, mem_addr;
  logic [DW-1:0] wr_data = '0, dout_data, mem_wdata, mem_rdata;
  logic          dout_valid, wr_ack, disp_buf, mem_en, mem_we;

  fb_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n), .dfetch(dfetch), .dnextframe(dnextframe),
    .fifo_level(fifo_level), .dout_data(dout_data), .dout_valid(dout_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .swap_req(swap_req), .disp_buf(disp_buf), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: returns {BEEF, 0..., read address} two cycles after a read.
  logic [AW-1:0] ra1 = '0, ra2 = '0;
  always @(posedge clk) begin
    ra1 <= mem_addr;
    ra2 <= ra1;
  end
  assign mem_rdata = {16'hBEEF, 224'd0, ra2};

  // FIFO model for the overrun run: fills on dout_valid, drains every 2nd cycle.
  bit fifo_auto = 1'b0;
  int lvl = 0, max_lvl = 0;
  assign fifo_level = fifo_auto ? 7'(lvl) : fifo_drv;

  int rd_cyc[$], rd_adr[$], wr_cyc[$], wr_adr[$], ack_cyc[$], dv_cyc[$], dv_dat[$];
  logic [DW-1:0] wr_dat[$];
  bit hold_wr = 1'b0, drop_wr = 1'b0;

  // Bus monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_en && !mem_we) begin rd_cyc.push_back(cyc); rd_adr.push_back(int'(mem_addr)); end
    if (mem_en && mem_we) begin
      wr_cyc.push_back(cyc); wr_adr.push_back(int'(mem_addr)); wr_dat.push_back(mem_wdata);
    end
    if (wr_ack) begin ack_cyc.push_back(cyc); if (!hold_wr) drop_wr = 1'b1; end
    if (dout_valid) begin dv_cyc.push_back(cyc); dv_dat.push_back(int'(dout_data[AW-1:0])); end
    if (fifo_auto) begin
      lvl = lvl + int'(dout_valid) - (((cyc % 2) == 0 && lvl > 0) ? 1 : 0);
      if (lvl > max_lvl) max_lvl = lvl;
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (drop_wr) begin wr_req = 1'b0; drop_wr = 1'b0; end
  endtask

  task automatic clr();
    rd_cyc.delete(); rd_adr.delete(); wr_cyc.delete(); wr_adr.delete();
    wr_dat.delete(); ack_cyc.delete(); dv_cyc.delete(); dv_dat.delete();
  endtask

  task automatic wait_rd(input int n, input int budget);
    int b = 0;
    while (rd_cyc.size() < n && b < budget) begin tick(); b++; end
  endtask

  // One burst trigger: FIFO empty for one decision cycle, then well above LOW_WM.
  task automatic start_burst();
    dfetch = 1'b1; fifo_drv = 7'd0;
    tick();
    fifo_drv = 7'd40;
  endtask

  logic [DW-1:0] WD;
  int ecyc, rcyc, late;

  initial begin
    WD = {8{32'hCAFE_0000}} ^ {{(DW-32){1'b0}}, 32'h0000_5A5A};

    // Reset state
    repeat (3) tick();
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_disp_buf", disp_buf, 0);
    reset_n = 1'b1;
    repeat (3) tick();

    // 1: full burst from address 0, returns MEM_LAT later
    clr(); start_burst(); repeat (25) tick();
    chk("t1_nrd", rd_cyc.size(), 16);
    for (int i = 0; i < rd_cyc.size(); i++) begin
      chk("t1_addr", rd_adr[i], i);
      chk("t1_rcyc", rd_cyc[i] - rd_cyc[0], i);
    end
    chk("t1_ndv", dv_cyc.size(), 16);
    for (int i = 0; i < dv_cyc.size(); i++) begin
      chk("t1_dvcyc", dv_cyc[i] - rd_cyc[0], i + 2);
      chk("t1_dvdat", dv_dat[i], i);
    end

    // 2: write held during a burst waits for the burst, then goes next cycle
    clr(); wr_addr = 16'h1234; wr_data = WD; wr_req = 1'b1;
    start_burst(); repeat (25) tick();
    chk("t2_nrd", rd_cyc.size(), 16);
    chk("t2_first", rd_adr[0], 16);
    chk("t2_last", rd_adr[15], 31);
    chk("t2_nwr", wr_cyc.size(), 1);
    chk("t2_wgap", wr_cyc[0] - rd_cyc[15], 1);
    chk("t2_waddr", wr_adr[0], 16'h1234);
    chk("t2_wdata_lo", wr_dat[0][63:0], WD[63:0]);
    chk("t2_wdata_hi", wr_dat[0][DW-1 -: 64], WD[DW-1 -: 64]);
    chk("t2_nack", ack_cyc.size(), 1);
    chk("t2_ackcyc", ack_cyc[0], wr_cyc[0]);

    // Bring dptr to 19192: restart, 8-read partial burst, then whole bursts
    dnextframe = 1'b0; tick(); dnextframe = 1'b1; tick();
    clr(); start_burst(); wait_rd(8, 20);
    dfetch = 1'b0; repeat (6) tick();
    chk("pre_nrd", rd_cyc.size(), 8);
    chk("pre_addr0", rd_adr[0], 0);
    clr(); dfetch = 1'b1; fifo_drv = 7'd0;
    wait_rd(1198 * 16 + 1, 25000);
    fifo_drv = 7'd40; repeat (25) tick();
    chk("ff_nrd", rd_cyc.size(), 1199 * 16);
    chk("ff_last", rd_adr[rd_adr.size() - 1], 19191);

    // 3: mid-burst wrap at end of frame
    clr(); start_burst(); repeat (25) tick();
    chk("t3_nrd", rd_cyc.size(), 16);
    for (int i = 0; i < rd_adr.size(); i++)
      chk("t3_addr", rd_adr[i], (i < 8) ? 19192 + i : i - 8);

    // 4: restart on the 5th read aborts the burst and drops in-flight data
    clr(); start_burst(); wait_rd(4, 20);
    dnextframe = 1'b0; ecyc = cyc;
    tick(); dnextframe = 1'b1; repeat (8) tick();
    chk("t4_nrd", rd_cyc.size(), 4);
    chk("t4_addr0", rd_adr[0], 8);
    chk("t4_ndv", dv_cyc.size(), 3);
    late = 0;
    foreach (dv_cyc[i]) if (dv_cyc[i] > ecyc) late++;
    chk("t4_late_dv", late, 0);
    clr(); start_burst(); repeat (25) tick();
    chk("t4_next_addr", rd_adr[0], 0);
    chk("t4_next_nrd", rd_cyc.size(), 16);
    chk("t4_next_ndv", dv_cyc.size(), 16);

    // 5: FIFO at LOW_WM, write held -> one write every 2 cycles, no reads
    clr(); fifo_drv = 7'd32; dfetch = 1'b1; hold_wr = 1'b1;
    wr_addr = 16'h0042; wr_req = 1'b1;
    repeat (20) tick();
    wr_req = 1'b0; hold_wr = 1'b0; repeat (4) tick();
    chk("t5_nrd", rd_cyc.size(), 0);
    chk("t5_nwr", wr_cyc.size(), 10);
    for (int i = 1; i < wr_cyc.size(); i++) chk("t5_gap", wr_cyc[i] - wr_cyc[i-1], 2);
    chk("t5_waddr", wr_adr[0], 16'h0042);

    // FIFO model: occupancy never exceeds FIFO_DEPTH
    clr(); lvl = 0; max_lvl = 0; fifo_auto = 1'b1;
    repeat (600) tick();
    dfetch = 1'b0; fifo_auto = 1'b0; fifo_drv = 7'd40; repeat (25) tick();
    chk("ovr_max", max_lvl <= 64, 1);
    chk("ovr_active", rd_cyc.size() > 64, 1);

    // Reset mid-burst: outputs clear at once, no further dout_valid
    clr(); start_burst(); wait_rd(3, 20);
    reset_n = 1'b0; rcyc = cyc; #1;
    chk("rst_mid_en", mem_en, 0);
    chk("rst_mid_dv", dout_valid, 0);
    tick(); tick(); reset_n = 1'b1; repeat (10) tick();
    late = 0;
    foreach (dv_cyc[i]) if (dv_cyc[i] >= rcyc) late++;
    foreach (rd_cyc[i]) if (rd_cyc[i] >= rcyc) late++;
    chk("rst_mid_late", late, 0);
    clr(); start_burst(); repeat (25) tick();
    chk("rst_mid_addr0", rd_adr[0], 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
